// File: rtl/mem_bus_pkg.sv
// Shared types and default memory map for the picorv32 native-bus decoder.
// Holds the FSM state encoding, slave-select struct and region constants.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2,
        DONE = 2'd3
    } bus_state_e;

    typedef struct packed {
        logic mem;
        logic io;
    } slave_sel_t;

    localparam logic [31:0] MEM_BASE_DEF = 32'h0000_0000;
    localparam logic [31:0] MEM_SIZE_DEF = 32'h0000_C000;
    localparam logic [31:0] IO_BASE_DEF  = 32'hFFFF_0000;
    localparam logic [31:0] IO_SIZE_DEF  = 32'h0001_0000;
    localparam int unsigned TIMEOUT_DEF  = 16;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

    // Counter value of the last WAIT cycle before a forced error completion.
    function automatic logic [7:0] timeout_last(input int unsigned timeout);
        return 8'(timeout - 32'd1);
    endfunction

endpackage

// File: rtl/mem_region_match.sv
// Combinational BASE/SIZE region hit test on a 32-bit byte address.
// The subtract-then-compare form stays correct when BASE+SIZE wraps past 2^32.
module mem_region_match #(
    parameter logic [31:0] BASE = 32'h0000_0000,
    parameter logic [31:0] SIZE = 32'h0000_1000
) (
    input  logic [31:0] addr,
    output logic        hit
);

    logic [31:0] offset_s;

    // Offset into the region; out-of-range addresses wrap to large unsigned values
    always_comb begin
        offset_s = addr - BASE;
        hit      = (offset_s < SIZE);
    end

endmodule

// File: rtl/mem_bus_decoder.sv
// picorv32 native-bus decoder: one-hot slave enables, shared ready/rdata
// return path, and guaranteed termination of unmapped or stalled requests.
module mem_bus_decoder
    import mem_bus_pkg::*;
#(
    parameter logic [31:0] MEM_BASE = MEM_BASE_DEF,
    parameter logic [31:0] MEM_SIZE = MEM_SIZE_DEF,
    parameter logic [31:0] IO_BASE  = IO_BASE_DEF,
    parameter logic [31:0] IO_SIZE  = IO_SIZE_DEF,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_valid,
    input  logic        cpu_instr,
    input  logic [31:0] cpu_addr,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    output logic        en_mem,
    output logic        en_io,
    input  logic        slv_ready,
    input  logic [31:0] slv_rdata,
    output logic        bus_err,
    output logic [31:0] err_addr
);

    localparam logic [7:0] CNT_LAST = timeout_last(TIMEOUT);

    bus_state_e  state_r;
    bus_state_e  state_nxt_s;
    slave_sel_t  en_sel_r;
    slave_sel_t  en_nxt_s;
    logic [7:0]  cnt_r;
    logic [31:0] req_addr_r;
    logic [31:0] err_addr_r;
    logic        mem_hit_s;
    logic        io_hit_s;
    logic        slv_ready_s;
    logic        cpu_ready_s;
    logic [31:0] cpu_rdata_s;

    mem_region_match #(
        .BASE (MEM_BASE),
        .SIZE (MEM_SIZE)
    ) u_match_mem (
        .addr (cpu_addr),
        .hit  (mem_hit_s)
    );

    mem_region_match #(
        .BASE (IO_BASE),
        .SIZE (IO_SIZE)
    ) u_match_io (
        .addr (cpu_addr),
        .hit  (io_hit_s)
    );

    // Only a driven 1 on the shared bus counts; floating or unknown reads as not ready
    always_comb begin
        slv_ready_s = (slv_ready === 1'b1);
    end

    // Next-state decode, next-cycle slave enables and CPU completion path
    always_comb begin
        state_nxt_s = state_r;
        en_nxt_s    = '0;
        cpu_ready_s = 1'b0;
        cpu_rdata_s = 32'h0000_0000;
        case (state_r)
            IDLE: begin
                if (cpu_valid) begin
                    if (mem_hit_s) begin
                        state_nxt_s  = WAIT;
                        en_nxt_s.mem = 1'b1;
                    end else if (io_hit_s && !cpu_instr) begin
                        state_nxt_s = WAIT;
                        en_nxt_s.io = 1'b1;
                    end else begin
                        state_nxt_s = ERR;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                // A withdrawn request is dropped silently; slave ready beats timeout
                if (!cpu_valid) begin
                    state_nxt_s = IDLE;
                end else if (slv_ready_s) begin
                    cpu_ready_s = 1'b1;
                    cpu_rdata_s = slv_rdata;
                    state_nxt_s = DONE;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ERR;
                end else begin
                    state_nxt_s = WAIT;
                    en_nxt_s    = en_sel_r;
                end
            end
            ERR: begin
                cpu_ready_s = 1'b1;
                cpu_rdata_s = ERR_DATA;
                state_nxt_s = DONE;
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, enables, wait counter and address capture
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r    <= IDLE;
            en_sel_r   <= '0;
            cnt_r      <= 8'd0;
            req_addr_r <= 32'h0000_0000;
            err_addr_r <= 32'h0000_0000;
        end else begin
            state_r  <= state_nxt_s;
            en_sel_r <= en_nxt_s;
            if ((state_r == WAIT) && (state_nxt_s == WAIT)) begin
                cnt_r <= cnt_r + 8'd1;
            end else begin
                cnt_r <= 8'd0;
            end
            if ((state_r == IDLE) && cpu_valid) begin
                req_addr_r <= cpu_addr;
            end else begin
                req_addr_r <= req_addr_r;
            end
            if (state_r == ERR) begin
                err_addr_r <= req_addr_r;
            end else begin
                err_addr_r <= err_addr_r;
            end
        end
    end

    assign cpu_ready = cpu_ready_s;
    assign cpu_rdata = cpu_rdata_s;
    assign en_mem    = en_sel_r.mem;
    assign en_io     = en_sel_r.io;
    assign bus_err   = (state_r == ERR);
    assign err_addr  = err_addr_r;

endmodule

// File: doc/mem_bus_decoder.md
Name: mem_bus_decoder

Overview:
- Sits between the picorv32 native memory interface and the bus slaves: the on-chip RAM block and the IO peripheral block.
- Decodes each CPU request address into a one-hot slave enable.
- Slaves share a tri-stated ready/rdata bus. This block samples that bus and returns ready/rdata to the CPU.
- Guarantees termination of every request:
  - unmapped addresses, instruction fetches from IO and non-responding slaves complete with an error word;
  - such requests raise a bus-error pulse.

Parameters:
- MEM_BASE, 32'h0000_0000, RAM region base (word aligned)
- MEM_SIZE, 32'h0000_C000, RAM region size in bytes (48 KiB)
- IO_BASE, 32'hFFFF_0000, IO region base
- IO_SIZE, 32'h0001_0000, IO region size in bytes
- TIMEOUT, 16, cycles in WAIT before forced error completion (2..255)
- ERR_DATA, 32'hDEAD_BEEF, rdata returned on any error completion

Ports:
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  synchronous, active-low reset
- cpu_valid  in  1  CPU request valid, held until cpu_ready
- cpu_instr  in  1  request is an instruction fetch
- cpu_addr  in  32  CPU byte address
- cpu_ready  out  1  one-cycle completion strobe to CPU
- cpu_rdata  out  32  read data to CPU, valid when cpu_ready
- en_mem  out  1  RAM slave enable
- en_io  out  1  IO slave enable
- slv_ready  in  1  shared tri-state ready from slaves; only 1'b1 counts as ready (z/x treated as 0)
- slv_rdata  in  32  shared tri-state read data from slaves
- bus_err  out  1  one-cycle pulse on error completion
- err_addr  out  32  address of the most recent error completion

Behaviour:
- Interface fixed: single clock clk; reset resetn is synchronous and active-low.
- Reset, taken at any clock edge with resetn==0 including mid-transaction:
  - state=IDLE, en_mem=0, en_io=0, cpu_ready=0, bus_err=0, err_addr=0, counter=0;
  - any in-flight request is abandoned without a ready.
- Region hit rules:
  - hit = (addr - BASE) < SIZE, unsigned 32-bit compare;
  - this is safe when BASE+SIZE wraps to 0, e.g. IO at 0xFFFF_0000;
  - MEM_BASE+MEM_SIZE-4 is mapped; MEM_BASE+MEM_SIZE is unmapped.
- FSM states: IDLE, WAIT, ERR, DONE.
- IDLE:
  - cpu_valid && mem hit -> WAIT, en_mem=1 from next cycle.
  - cpu_valid && io hit && !cpu_instr -> WAIT, en_io=1.
  - cpu_valid otherwise (unmapped, or instruction fetch from IO) -> ERR; no enable is ever asserted.
- Decode result is registered. Enables are registered outputs, driven only in WAIT.
- WAIT:
  - counter increments each cycle.
  - slv_ready==1: cpu_ready=1 and cpu_rdata=slv_rdata, both combinational in that cycle; -> DONE.
  - counter==TIMEOUT-1 with no ready -> ERR.
  - cpu_valid drops (protocol violation) -> IDLE, enables cleared, no ready.
- ERR (one cycle):
  - cpu_ready=1, cpu_rdata=ERR_DATA, bus_err=1;
  - err_addr latched from the registered request address;
  - -> DONE.
- DONE (one cycle):
  - all enables low, so the slave's registered ready clears;
  - a new cpu_valid is ignored this cycle;
  - -> IDLE.
  - Minimum request spacing is therefore 3 cycles for an immediate-error request (IDLE, ERR, DONE).
- cpu_ready is high exactly one cycle per request. cpu_rdata=0 whenever cpu_ready=0.
- Writes use cpu_wstrb, which is routed directly from CPU to slaves and not by this block.
- An error completion of a write performs no write, because no enable is asserted.
- If slv_ready and timeout coincide in the same WAIT cycle, slave ready wins (normal completion).
- Latency:
  - RAM slave responds on negedge after enable, so a RAM read completes in the 2nd WAIT cycle: cpu_ready 2 cycles after cpu_valid is first sampled;
  - unmapped request: cpu_ready 1 cycle after cpu_valid sampled.

Decomposition:
- Shared package mem_bus_pkg holds:
  - the state enum (IDLE/WAIT/ERR/DONE);
  - region base/size constants;
  - ERR_DATA.
- One natural sub-module: mem_region_match (combinational BASE/SIZE hit test), instantiated twice.

Test Plan:
- Read 0x0000_0100, RAM model holds 0x1234_5678 -> en_mem high for 2 cycles, cpu_ready single pulse 2 cycles after valid, cpu_rdata=0x1234_5678, bus_err=0.
- Read 0x8000_0000 (unmapped) -> no enable, cpu_ready 1 cycle after valid, rdata 0xDEAD_BEEF, bus_err pulse, err_addr=0x8000_0000. Repeat with 0x0000_C000 (error) and 0x0000_BFFC (RAM).
- Read 0xFFFF_0010, IO model never drives ready -> en_io high 16 cycles, then ERR completion with 0xDEAD_BEEF, bus_err pulse.
- Instruction fetch at 0xFFFF_0000 -> immediate error, en_io never asserted.
- Back-to-back RAM writes, wstrb=4'b1111, valid reasserted right after ready -> one DONE gap, exactly one cpu_ready per request, both words written.
- resetn=0 for one cycle mid-WAIT on an IO access -> next cycle all outputs 0, no cpu_ready; a following RAM read completes normally.
